// File: rtl/dsp_post_adder_acc_pkg.sv
// rtl/dsp_post_adder_acc_pkg.sv - shared operand-select codes and opmode bit positions
package dsp_post_adder_acc_pkg;

   // X operand select, opmode[1:0]
   localparam logic [1:0] X_ZERO = 2'd0;
   localparam logic [1:0] X_M    = 2'd1;
   localparam logic [1:0] X_P    = 2'd2;
   localparam logic [1:0] X_DAB  = 2'd3;

   // Z operand select, opmode[3:2]
   localparam logic [1:0] Z_ZERO = 2'd0;
   localparam logic [1:0] Z_PCIN = 2'd1;
   localparam logic [1:0] Z_P    = 2'd2;
   localparam logic [1:0] Z_C    = 2'd3;

   // opmode field positions
   localparam int OPM_X_LSB = 0;
   localparam int OPM_Z_LSB = 2;
   localparam int OPM_CIN   = 5;
   localparam int OPM_SUB   = 7;

endpackage

// File: rtl/dsp_post_adder_acc_if.sv
// rtl/dsp_post_adder_acc_if.sv - control, operand and result bundle of the post-adder
interface dsp_post_adder_acc_if #(
   parameter int M_WIDTH = 36,
   parameter int P_WIDTH = 48
) ();

   logic               ce_opmode;
   logic               ce_cin;
   logic               ce_p;
   logic [7:0]         opmode;
   logic [M_WIDTH-1:0] m;
   logic [P_WIDTH-1:0] dab;
   logic [P_WIDTH-1:0] c;
   logic [P_WIDTH-1:0] pcin;
   logic [P_WIDTH-1:0] p;
   logic [P_WIDTH-1:0] pcout;
   logic               carryout;
   logic               carryoutf;

   modport master (
      output ce_opmode, ce_cin, ce_p, opmode, m, dab, c, pcin,
      input  p, pcout, carryout, carryoutf
   );

   modport slave (
      input  ce_opmode, ce_cin, ce_p, opmode, m, dab, c, pcin,
      output p, pcout, carryout, carryoutf
   );

endinterface

// File: rtl/dsp_post_adder_acc_register.sv
// rtl/dsp_post_adder_acc_register.sv - pipeline register with clock enable and selectable reset style
module dsp_post_adder_acc_register #(
   parameter int    WIDTH    = 1,
   parameter string RST_TYPE = "SYNC"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (RST_TYPE == "ASYNC") begin : g_async
         // reset takes effect immediately; ce gates normal loads only
         always_ff @(posedge clk or posedge rst) begin
            if (rst)     q <= '0;
            else if (ce) q <= d;
         end
      end else begin : g_sync
         // reset sampled on the clock edge and wins over ce
         always_ff @(posedge clk) begin
            if (rst)     q <= '0;
            else if (ce) q <= d;
         end
      end
   endgenerate

endmodule

// File: rtl/dsp_post_adder_acc.sv
// rtl/dsp_post_adder_acc.sv - post-adder/accumulator: Z +/- (X + cin) into P and carryout
module dsp_post_adder_acc
   import dsp_post_adder_acc_pkg::*;
#(
   parameter int M_WIDTH    = 36,
   parameter int P_WIDTH    = 48,
   parameter int OPMODEREG  = 1,
   parameter int CARRYINREG = 1,
   parameter int PREG       = 1
) (
   input logic                 clk,
   input logic                 rst,
   dsp_post_adder_acc_if.slave bus
);

   logic [7:0]         opmode_r;
   logic               cin_r;
   logic [P_WIDTH-1:0] p_q;
   logic               co_q;
   logic [P_WIDTH-1:0] p_fb;
   logic [P_WIDTH:0]   x_ext;
   logic [P_WIDTH:0]   z_ext;
   logic [P_WIDTH:0]   cin_ext;
   logic [P_WIDTH:0]   sum;
   logic               unused_opmode_bits;

   // bits 4 and 6 of opmode carry no meaning in this stage
   assign unused_opmode_bits = ^{opmode_r[6], opmode_r[4]};

   generate
      if (OPMODEREG != 0) begin : g_opmode_reg
         dsp_post_adder_acc_register #(.WIDTH(8), .RST_TYPE("SYNC")) u_opmode_reg (
            .clk (clk),
            .rst (rst),
            .ce  (bus.ce_opmode),
            .d   (bus.opmode),
            .q   (opmode_r)
         );
      end else begin : g_opmode_comb
         assign opmode_r = bus.opmode;
      end

      if (CARRYINREG != 0) begin : g_cin_reg
         dsp_post_adder_acc_register #(.WIDTH(1), .RST_TYPE("SYNC")) u_cin_reg (
            .clk (clk),
            .rst (rst),
            .ce  (bus.ce_cin),
            .d   (opmode_r[OPM_CIN]),
            .q   (cin_r)
         );
      end else begin : g_cin_comb
         assign cin_r = opmode_r[OPM_CIN];
      end
   endgenerate

   // Without a P register there is nothing safe to feed back, so P reads as 0
   // in both muxes and no combinational loop can form.
   assign p_fb = (PREG != 0) ? p_q : '0;

   // operand selection and the P_WIDTH+1 bit add/subtract
   always_comb begin
      x_ext   = '0;
      z_ext   = '0;
      cin_ext = {{P_WIDTH{1'b0}}, cin_r};
      sum     = '0;
      case (opmode_r[OPM_X_LSB +: 2])
         X_ZERO:  x_ext = '0;
         X_M:     x_ext = {{(P_WIDTH + 1 - M_WIDTH){1'b0}}, bus.m};
         X_P:     x_ext = {1'b0, p_fb};
         default: x_ext = {1'b0, bus.dab};
      endcase
      case (opmode_r[OPM_Z_LSB +: 2])
         Z_ZERO:  z_ext = '0;
         Z_PCIN:  z_ext = {1'b0, bus.pcin};
         Z_P:     z_ext = {1'b0, p_fb};
         default: z_ext = {1'b0, bus.c};
      endcase
      if (opmode_r[OPM_SUB]) sum = z_ext - (x_ext + cin_ext);
      else                   sum = z_ext + x_ext + cin_ext;
   end

   generate
      if (PREG != 0) begin : g_p_reg
         dsp_post_adder_acc_register #(.WIDTH(P_WIDTH), .RST_TYPE("SYNC")) u_p_reg (
            .clk (clk),
            .rst (rst),
            .ce  (bus.ce_p),
            .d   (sum[P_WIDTH-1:0]),
            .q   (p_q)
         );
         dsp_post_adder_acc_register #(.WIDTH(1), .RST_TYPE("SYNC")) u_co_reg (
            .clk (clk),
            .rst (rst),
            .ce  (bus.ce_p),
            .d   (sum[P_WIDTH]),
            .q   (co_q)
         );
      end else begin : g_p_comb
         assign p_q  = sum[P_WIDTH-1:0];
         assign co_q = sum[P_WIDTH];
      end
   endgenerate

   assign bus.p         = p_q;
   assign bus.pcout     = p_q;
   assign bus.carryout  = co_q;
   assign bus.carryoutf = co_q;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// tb/tb_dsp_post_adder_acc.sv - directed scoreboard bench for the post-adder/accumulator
module tb_dsp_post_adder_acc;

   localparam int MW = 36;
   localparam int PW = 48;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   logic [PW:0] exp_q[$];

   always #5 clk = ~clk;

   dsp_post_adder_acc_if #(.M_WIDTH(MW), .P_WIDTH(PW)) bus ();

   dsp_post_adder_acc #(
      .M_WIDTH(MW), .P_WIDTH(PW), .OPMODEREG(1), .CARRYINREG(1), .PREG(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_p(input logic [PW-1:0] p, input logic co);
      exp_q.push_back({co, p});
   endtask

   task automatic check(input string tag);
      logic [PW:0] e;
      n_assert++;
      assert (exp_q.size() != 0) else begin
         n_fail++;
         $error("FAIL %s scoreboard observed=empty expected=entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_assert++;
         assert (bus.p === e[PW-1:0]) else begin
            n_fail++;
            $error("FAIL %s p observed=%h expected=%h", tag, bus.p, e[PW-1:0]);
         end
         n_assert++;
         assert (bus.pcout === e[PW-1:0]) else begin
            n_fail++;
            $error("FAIL %s pcout observed=%h expected=%h", tag, bus.pcout, e[PW-1:0]);
         end
         n_assert++;
         assert (bus.carryout === e[PW]) else begin
            n_fail++;
            $error("FAIL %s carryout observed=%b expected=%b", tag, bus.carryout, e[PW]);
         end
         n_assert++;
         assert (bus.carryoutf === e[PW]) else begin
            n_fail++;
            $error("FAIL %s carryoutf observed=%b expected=%b", tag, bus.carryoutf, e[PW]);
         end
      end
   endtask

   initial begin
      logic [PW-1:0] rc;
      logic [PW-1:0] rd;
      logic [PW:0]   s;

      bus.ce_opmode = 1'b1;
      bus.ce_cin    = 1'b1;
      bus.ce_p      = 1'b1;

      // 1: reset with random inputs
      for (int i = 0; i < 2; i++) begin
         bus.opmode = 8'($urandom);
         bus.m      = {4'($urandom), 32'($urandom)};
         bus.dab    = {16'($urandom), 32'($urandom)};
         bus.c      = {16'($urandom), 32'($urandom)};
         bus.pcin   = {16'($urandom), 32'($urandom)};
         tick(1);
      end
      expect_p('0, 1'b0);
      check("reset");
      rst = 1'b0;
      bus.pcin = '0;
      bus.dab  = '0;

      // 2: add, opmode reaches the adder one cycle late
      bus.opmode = 8'h0D;
      bus.m      = 36'd5;
      bus.c      = 48'd10;
      tick(1);
      expect_p('0, 1'b0);
      check("add_latency_1");
      tick(1);
      expect_p(48'd15, 1'b0);
      check("add_c_plus_m");

      // 3: subtract with carry-in, then borrow
      bus.opmode = 8'hAD;
      bus.m      = 36'd3;
      tick(3);
      expect_p(48'd6, 1'b0);
      check("sub_cin");
      bus.c = 48'd2;
      tick(1);
      expect_p(48'hFFFF_FFFF_FFFE, 1'b1);
      check("sub_borrow");

      // 4: accumulate from a cleared P
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expect_p('0, 1'b0);
      check("acc_clear");
      bus.opmode = 8'h09;
      bus.m      = 36'd7;
      bus.ce_p   = 1'b0;
      tick(3);
      expect_p('0, 1'b0);
      check("acc_ce_low_settle");
      bus.ce_p = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         expect_p(48'(7 * k), 1'b0);
         check($sformatf("acc_step%0d", k));
      end
      bus.ce_p = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick(1);
         expect_p(48'd28, 1'b0);
         check($sformatf("acc_hold%0d", k));
      end
      bus.ce_p = 1'b1;

      // 5: overflow wrap, then random dab + c sums
      bus.opmode = 8'h0F;
      bus.dab    = 48'hFFFF_FFFF_FFFF;
      bus.c      = 48'd1;
      tick(2);
      expect_p('0, 1'b1);
      check("wrap");
      for (int i = 0; i < 4; i++) begin
         rd = {16'($urandom), 32'($urandom)};
         rc = {16'($urandom), 32'($urandom)};
         bus.dab = rd;
         bus.c   = rc;
         s = {1'b0, rc} + {1'b0, rd};
         expect_p(s[PW-1:0], s[PW]);
         tick(1);
         check($sformatf("rand_add%0d", i));
      end

      // 6: cascade in, accumulate, reset mid-accumulation
      bus.opmode = 8'h04;
      bus.pcin   = 48'd100;
      tick(2);
      expect_p(48'd100, 1'b0);
      check("cascade");
      bus.opmode = 8'h09;
      tick(2);
      expect_p(48'd107, 1'b0);
      check("cascade_acc1");
      tick(1);
      expect_p(48'd114, 1'b0);
      check("cascade_acc2");
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expect_p('0, 1'b0);
      check("mid_reset");
      tick(1);
      expect_p('0, 1'b0);
      check("resume_opmode_delay");
      tick(1);
      expect_p(48'd7, 1'b0);
      check("resume1");
      tick(1);
      expect_p(48'd14, 1'b0);
      check("resume2");

      n_assert++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL leftover observed=%0d expected=0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
